stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Parametrised synchronous FIFO with valid/ready handshakes on both sides.
- Successor to the team's basic count-based FIFO. Adds:
  - a selectable output register stage
  - a synchronous flush
  - programmable almost-full and almost-empty flags
  - an occupancy output
  - sticky error flags for handshake-protocol violations
- Used as the buffering element between AXI channel stages, e.g. the W/R data paths and the B/R response queues.

Parameters:
- DATA_WIDTH, 32: payload width in bits.
- DEPTH, 4: storage RAM entries. Must be a power of 2 and ≥2.
- OUT_REG, 0:
  - 0: head of the queue is driven directly from the storage array.
  - 1: adds one registered output slot.
- AF_THRESH, DEPTH-1: almost_full asserts when level ≥ AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when level ≤ AE_THRESH.

Ports:
- clk, input, 1: clock, rising edge.
- clr, input, 1: reset, asynchronous, active-high.
- flush, input, 1: synchronous clear of all contents.
- s_valid, input, 1: write-side data valid.
- s_ready, output, 1: FIFO can accept data.
- s_data, input, DATA_WIDTH: write data.
- m_valid, output, 1: read-side data valid.
- m_ready, input, 1: consumer accepts data.
- m_data, output, DATA_WIDTH: head-of-queue data.
- level, output, $clog2(DEPTH+2): number of entries held.
- almost_full, output, 1: level ≥ AF_THRESH.
- almost_empty, output, 1: level ≤ AE_THRESH.
- proto_err, output, 1: sticky flag; s_valid was dropped, or s_data changed, while s_ready was low.

Behaviour:
- Reset (clr high, asynchronous):
  - Pointers, level, output slot and proto_err clear to 0.
  - m_data = 0, m_valid = 0, s_ready = 0.
  - While clr is high, s_ready is held low.
  - s_ready rises in the first cycle after clr deasserts.
  - Reset mid-transfer discards all contents; no partial state survives.
- Capacity: CAP = DEPTH + OUT_REG.
  - level counts RAM entries plus the output slot when it is occupied.
- Push and pop:
  - push occurs on a rising edge when s_valid && s_ready.
  - pop occurs on a rising edge when m_valid && m_ready.
- s_ready = !clr && !flush && (level < CAP).
  - It depends on registered level only: no same-cycle pass-through.
  - At full, a push is refused even if a pop occurs in the same cycle.
- OUT_REG=0:
  - m_valid = (level ≠ 0) && !flush.
  - m_data = mem[rd_ptr].
  - A push into an empty FIFO at edge k gives m_valid high after edge k.
- OUT_REG=1:
  - m_valid and m_data come from the output slot registers.
  - The slot loads from RAM when it is empty, or is being popped, and the RAM is non-empty.
  - A push into an empty FIFO gives m_valid after the second edge.
  - The head RAM entry moves into the slot on the same edge the slot is popped, so back-to-back pops sustain 1 word/cycle.
  - m_data holds its last value when m_valid is low.
- Level update:
  - Push without pop: +1.
  - Pop without push: −1.
  - Both, or neither: unchanged.
  - Level never exceeds CAP and never underflows.
- Pointers:
  - Width $clog2(DEPTH).
  - They wrap from DEPTH-1 to 0 with no gap.
  - Ordering is strictly FIFO across the wrap.
- Flush (synchronous):
  - At the edge, clears pointers, level and the output slot.
  - Overrides any push or pop presented in the same cycle; that data is discarded.
  - During the flush cycle, s_ready = 0 and m_valid = 0.
  - proto_err is not cleared by flush; only clr clears it.
- Flags:
  - almost_full and almost_empty are combinational from registered level.
  - Both update the cycle after the push or pop that changes level.
- proto_err:
  - Sets when, in a cycle with s_valid high and s_ready low, the next cycle has s_valid low or different s_data, without an intervening handshake.
  - Flush cycles are excluded.

Test Plan:
1. Fill/drain (DATA_WIDTH=8, DEPTH=4, OUT_REG=0):
   - Push 0x11, 0x22, 0x33, 0x44 with m_ready=0 → level = 4, s_ready = 0, almost_full = 1.
   - Pop all → data out in order 0x11..0x44, then m_valid = 0, level = 0, almost_empty = 1.
2. Wrap-around:
   - Stream 10 words 0x00..0x09 with s_valid=1 and m_ready=1 continuously → output sequence identical to input, no gaps after the first word, level ≤ 1 throughout.
3. OUT_REG=1 latency and throughput:
   - Single push of 0xA5 into an empty FIFO → m_valid asserts after the 2nd edge with m_data = 0xA5.
   - Fill to 5 entries, then m_ready=1 → 5 pops on 5 consecutive cycles.
4. Full boundary:
   - At level = CAP, assert s_valid and m_ready together → the pop completes and the push is refused that cycle (level goes 4→3).
   - The push is accepted on the next cycle (level 3→4).
5. Flush:
   - With level = 3, assert flush together with s_valid=1 and m_ready=1 → next cycle level = 0 and m_valid = 0.
   - The pushed word never appears at the output.
   - proto_err is unchanged.
6. Reset mid-operation:
   - Assert clr asynchronously between edges at level = 2 → level = 0, m_valid = 0, m_data = 0 immediately.
   - After release, the FIFO operates normally from empty.
   - Additionally: drop s_valid while s_ready = 0 → proto_err = 1 and stays 1 until clr.

Source files
------------

// File: rtl/stream_fifo.sv
// stream_fifo: parametrised synchronous FIFO with valid/ready handshakes on
// both sides. It offers an optional registered output slot, a synchronous
// flush, almost-full/almost-empty flags, an occupancy count, and a sticky flag
// for write-side handshake violations.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready. A producer that raises valid must hold valid and data
// stable until the transfer happens. Ready never depends combinationally on
// valid on the same side.
//
// Ports:
//   clk          in   rising-edge clock
//   clr          in   asynchronous active-high reset
//   flush        in   synchronous clear of all contents
//   s_valid      in   write-side data valid
//   s_ready      out  FIFO can accept data (from registered level only)
//   s_data       in   write data
//   m_valid      out  read-side data valid
//   m_ready      in   consumer accepts data
//   m_data       out  head-of-queue data
//   level        out  entries held (RAM plus output slot when occupied)
//   almost_full  out  level >= AF_THRESH
//   almost_empty out  level <= AE_THRESH
//   proto_err    out  sticky: s_valid dropped or s_data changed while stalled
module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int OUT_REG    = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          flush,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH+2)-1:0]    level,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          proto_err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 2);
  localparam int CAP = DEPTH + OUT_REG;
  localparam logic [LW-1:0] CAP_L = LW'(CAP);
  localparam logic [LW-1:0] AF_L  = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L  = LW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         ram_count;
  logic                  ram_empty;
  logic                  ram_pop;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] ram_head;

  assign ram_head  = mem[rd_ptr];
  assign ram_empty = (ram_count == '0);

  // Registered level only: a pop in the same cycle never frees room for a push.
  assign s_ready = !clr && !flush && (level < CAP_L);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  slot_valid;
    logic [DATA_WIDTH-1:0] slot_data;
    logic                  slot_load;

    // Refill the slot on the same edge it is popped, so back-to-back pops
    // keep one word per cycle.
    assign slot_load = (!slot_valid || pop) && !ram_empty;
    assign ram_pop   = slot_load;
    assign level     = ram_count + LW'(slot_valid);
    assign m_valid   = slot_valid && !flush;
    assign m_data    = slot_data;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        slot_valid <= 1'b0;
        slot_data  <= '0;
      end else if (flush) begin
        slot_valid <= 1'b0;
        slot_data  <= '0;
      end else if (slot_load) begin
        slot_valid <= 1'b1;
        slot_data  <= ram_head;
      end else if (pop) begin
        // slot_data keeps the last word while m_valid is low
        slot_valid <= 1'b0;
      end
    end
  end else begin : g_direct
    assign ram_pop = pop;
    assign level   = ram_count;
    assign m_valid = !ram_empty && !flush;
    assign m_data  = ram_head;
  end

  // Storage and pointers. The array is cleared on clr so that the unregistered
  // head reads zero out of reset. DEPTH is a power of two, so the pointers
  // wrap naturally.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (ram_pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !ram_pop)      ram_count <= ram_count + LW'(1);
      else if (!push && ram_pop) ram_count <= ram_count - LW'(1);
    end
  end

  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // Protocol watch. stall_q remembers a cycle where the producer offered data
  // that was not taken. The next cycle must keep s_valid high with the same
  // data. Flush cycles neither start nor judge a stall.
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] stall_data_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
      proto_err    <= 1'b0;
    end else begin
      stall_q      <= s_valid && !s_ready && !flush;
      stall_data_q <= s_data;
      if (stall_q && !flush && (!s_valid || (s_data != stall_data_q)))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo. Instance a is DATA_WIDTH=8, DEPTH=4,
// OUT_REG=0 (CAP=4). Instance b is the same with OUT_REG=1 (CAP=5). Both
// instances share clk and clr. Inputs change 1ns after each rising edge, and
// outputs are checked after a further 1ns settle.
module tb_stream_fifo;

  logic       clk;
  logic       clr;

  logic       a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
  logic [7:0] a_s_data, a_m_data;
  logic [2:0] a_level;
  logic       a_af, a_ae, a_perr;

  logic       b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [7:0] b_s_data, b_m_data;
  logic [2:0] b_level;
  logic       b_af, b_ae, b_perr;

  int total;
  int bad;
  logic [7:0] exp_q[$];

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(0)) u_a (
    .clk(clk), .clr(clr), .flush(a_flush),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .level(a_level), .almost_full(a_af), .almost_empty(a_ae), .proto_err(a_perr)
  );

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(1)) u_b (
    .clk(clk), .clr(clr), .flush(b_flush),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .level(b_level), .almost_full(b_af), .almost_empty(b_ae), .proto_err(b_perr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [7:0] d);
    a_s_valid = 1'b1;
    a_s_data  = d;
    tick();
    a_s_valid = 1'b0;
  endtask

  task automatic b_push(input logic [7:0] d);
    b_s_valid = 1'b1;
    b_s_data  = d;
    tick();
    b_s_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (a_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", a_level); end
    total++; if (a_m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", a_m_valid); end
    total++; if (a_s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b exp=0", a_s_ready); end
    total++; if (a_m_data !== 8'h00) begin bad++; $display("FAIL rst_m_data got=%h exp=00", a_m_data); end
    total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%b exp=0", a_perr); end
    total++; if (b_m_valid !== 1'b0 || b_m_data !== 8'h00 || b_s_ready !== 1'b0) begin
      bad++; $display("FAIL rst_b got mv=%b md=%h sr=%b exp 0/00/0", b_m_valid, b_m_data, b_s_ready);
    end
    tick();
    tick();
    total++; if (a_s_ready !== 1'b0) begin bad++; $display("FAIL rst_hold_s_ready got=%b exp=0", a_s_ready); end
    clr = 1'b0;
    #1;
    total++; if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_s_ready got a=%b b=%b exp=1", a_s_ready, b_s_ready);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] words [4];
    int lvl;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int i = 0; i < 4; i++) a_push(words[i]);
    #1;
    total++; if (a_level !== 3'd4) begin bad++; $display("FAIL fill_level got=%0d exp=4", a_level); end
    total++; if (a_s_ready !== 1'b0) begin bad++; $display("FAIL fill_s_ready got=%b exp=0", a_s_ready); end
    total++; if (a_af !== 1'b1) begin bad++; $display("FAIL fill_almost_full got=%b exp=1", a_af); end
    a_m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lvl = 4 - i;
      #1;
      total++; if (a_m_valid !== 1'b1 || a_m_data !== words[i]) begin
        bad++; $display("FAIL drain_data[%0d] got mv=%b md=%h exp 1/%h", i, a_m_valid, a_m_data, words[i]);
      end
      total++; if (a_level !== 3'(lvl) || a_af !== (lvl >= 3) || a_ae !== (lvl <= 1)) begin
        bad++; $display("FAIL drain_flags[%0d] got lvl=%0d af=%b ae=%b exp lvl=%0d af=%b ae=%b",
                        i, a_level, a_af, a_ae, lvl, (lvl >= 3), (lvl <= 1));
      end
      tick();
    end
    a_m_ready = 1'b0;
    #1;
    total++; if (a_m_valid !== 1'b0 || a_level !== 3'd0 || a_ae !== 1'b1) begin
      bad++; $display("FAIL drain_empty got mv=%b lvl=%0d ae=%b exp 0/0/1", a_m_valid, a_level, a_ae);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d;
    a_m_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      a_s_valid = (c < 10);
      a_s_data  = 8'(c);
      #1;
      total++; if (a_level > 3'd1) begin bad++; $display("FAIL wrap_level[%0d] got=%0d exp<=1", c, a_level); end
      if (c == 0) begin
        total++; if (a_m_valid !== 1'b0) begin bad++; $display("FAIL wrap_first_valid got=%b exp=0", a_m_valid); end
      end else begin
        exp_d = exp_q.pop_front();
        total++; if (a_m_valid !== 1'b1 || a_m_data !== exp_d) begin
          bad++; $display("FAIL wrap_out[%0d] got mv=%b md=%h exp 1/%h", c, a_m_valid, a_m_data, exp_d);
        end
      end
      if (c < 10) exp_q.push_back(8'(c));
      tick();
    end
    a_s_valid = 1'b0;
    a_m_ready = 1'b0;
    #1;
    total++; if (a_level !== 3'd0 || a_m_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_end got lvl=%0d mv=%b exp 0/0", a_level, a_m_valid);
    end
  endtask

  task automatic test_out_reg();
    b_push(8'hA5);
    #1;
    total++; if (b_m_valid !== 1'b0 || b_level !== 3'd1) begin
      bad++; $display("FAIL oreg_edge1 got mv=%b lvl=%0d exp 0/1", b_m_valid, b_level);
    end
    tick();
    total++; if (b_m_valid !== 1'b1 || b_m_data !== 8'hA5) begin
      bad++; $display("FAIL oreg_edge2 got mv=%b md=%h exp 1/a5", b_m_valid, b_m_data);
    end
    b_m_ready = 1'b1;
    tick();
    b_m_ready = 1'b0;
    #1;
    total++; if (b_m_valid !== 1'b0 || b_level !== 3'd0 || b_m_data !== 8'hA5) begin
      bad++; $display("FAIL oreg_hold got mv=%b lvl=%0d md=%h exp 0/0/a5", b_m_valid, b_level, b_m_data);
    end
    for (int i = 0; i < 5; i++) b_push(8'h10 + 8'(i));
    #1;
    total++; if (b_level !== 3'd5 || b_s_ready !== 1'b0) begin
      bad++; $display("FAIL oreg_full got lvl=%0d sr=%b exp 5/0", b_level, b_s_ready);
    end
    b_m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (b_m_valid !== 1'b1 || b_m_data !== 8'h10 + 8'(i)) begin
        bad++; $display("FAIL oreg_pop[%0d] got mv=%b md=%h exp 1/%h", i, b_m_valid, b_m_data, 8'h10 + 8'(i));
      end
      tick();
    end
    b_m_ready = 1'b0;
    #1;
    total++; if (b_m_valid !== 1'b0 || b_level !== 3'd0) begin
      bad++; $display("FAIL oreg_empty got mv=%b lvl=%0d exp 0/0", b_m_valid, b_level);
    end
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 4; i++) a_push(8'h51 + 8'(i));
    a_s_valid = 1'b1;
    a_s_data  = 8'h55;
    a_m_ready = 1'b1;
    #1;
    total++; if (a_s_ready !== 1'b0 || a_m_data !== 8'h51) begin
      bad++; $display("FAIL full_refuse got sr=%b md=%h exp 0/51", a_s_ready, a_m_data);
    end
    tick();
    total++; if (a_level !== 3'd3 || a_s_ready !== 1'b1) begin
      bad++; $display("FAIL full_after_pop got lvl=%0d sr=%b exp 3/1", a_level, a_s_ready);
    end
    a_m_ready = 1'b0;
    tick();
    a_s_valid = 1'b0;
    #1;
    total++; if (a_level !== 3'd4 || a_perr !== 1'b0) begin
      bad++; $display("FAIL full_retry got lvl=%0d perr=%b exp 4/0", a_level, a_perr);
    end
    a_m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (a_m_data !== 8'h52 + 8'(i)) begin
        bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, a_m_data, 8'h52 + 8'(i));
      end
      tick();
    end
    a_m_ready = 1'b0;
  endtask

  task automatic test_flush();
    a_push(8'h61);
    a_push(8'h62);
    a_push(8'h63);
    #1;
    total++; if (a_level !== 3'd3) begin bad++; $display("FAIL flush_pre_level got=%0d exp=3", a_level); end
    a_flush   = 1'b1;
    a_s_valid = 1'b1;
    a_s_data  = 8'h99;
    a_m_ready = 1'b1;
    #1;
    total++; if (a_s_ready !== 1'b0 || a_m_valid !== 1'b0) begin
      bad++; $display("FAIL flush_cycle got sr=%b mv=%b exp 0/0", a_s_ready, a_m_valid);
    end
    tick();
    a_flush   = 1'b0;
    a_s_valid = 1'b0;
    a_m_ready = 1'b0;
    #1;
    total++; if (a_level !== 3'd0 || a_m_valid !== 1'b0 || a_perr !== 1'b0) begin
      bad++; $display("FAIL flush_after got lvl=%0d mv=%b perr=%b exp 0/0/0", a_level, a_m_valid, a_perr);
    end
    a_push(8'h71);
    #1;
    total++; if (a_level !== 3'd1 || a_m_data !== 8'h71) begin
      bad++; $display("FAIL flush_next got lvl=%0d md=%h exp 1/71", a_level, a_m_data);
    end
    a_m_ready = 1'b1;
    tick();
    a_m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_push(8'h81);
    a_push(8'h82);
    #3;
    clr = 1'b1;
    #1;
    total++; if (a_level !== 3'd0 || a_m_valid !== 1'b0 || a_m_data !== 8'h00 || a_s_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid got lvl=%0d mv=%b md=%h sr=%b exp 0/0/00/0", a_level, a_m_valid, a_m_data, a_s_ready);
    end
    tick();
    clr = 1'b0;
    a_push(8'h83);
    #1;
    total++; if (a_level !== 3'd1 || a_m_valid !== 1'b1 || a_m_data !== 8'h83) begin
      bad++; $display("FAIL rstmid_resume got lvl=%0d mv=%b md=%h exp 1/1/83", a_level, a_m_valid, a_m_data);
    end
    a_m_ready = 1'b1;
    tick();
    a_m_ready = 1'b0;
  endtask

  task automatic test_proto_err();
    for (int i = 0; i < 4; i++) a_push(8'h91 + 8'(i));
    a_s_valid = 1'b1;
    a_s_data  = 8'h95;
    tick();
    total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL perr_stall got=%b exp=0", a_perr); end
    a_s_valid = 1'b0;
    tick();
    total++; if (a_perr !== 1'b1) begin bad++; $display("FAIL perr_drop got=%b exp=1", a_perr); end
    tick();
    tick();
    total++; if (a_perr !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%b exp=1", a_perr); end
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    #1;
    total++; if (a_perr !== 1'b1 || a_level !== 3'd0) begin
      bad++; $display("FAIL perr_flush got perr=%b lvl=%0d exp 1/0", a_perr, a_level);
    end
    clr = 1'b1;
    #1;
    total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL perr_clr got=%b exp=0", a_perr); end
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) a_push(8'hB1 + 8'(i));
    a_s_valid = 1'b1;
    a_s_data  = 8'hA0;
    tick();
    a_s_data  = 8'hA1;
    tick();
    a_s_valid = 1'b0;
    #1;
    total++; if (a_perr !== 1'b1) begin bad++; $display("FAIL perr_data_change got=%b exp=1", a_perr); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr = 1'b1;
    a_flush = 1'b0; a_s_valid = 1'b0; a_s_data = 8'h00; a_m_ready = 1'b0;
    b_flush = 1'b0; b_s_valid = 1'b0; b_s_data = 8'h00; b_m_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_out_reg();
    test_full_boundary();
    test_flush();
    test_reset_mid();
    test_proto_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
